// File: rtl/leak_key_recover_pkg.sv
// leak_pkg: shared widths, FSM states, row type and key bit indexing for leak_key_recover
package leak_pkg;
  localparam int PW = 8;
  localparam int NK = 8;
  localparam int KW = $clog2(PW);
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_REDUCE, S_BACKSUB, S_DONE} state_t;
  typedef struct packed {
    logic [PW-1:0] p;
    logic [NK-1:0] r;
  } row_t;
  function automatic int key_index(int j, int k);
    return PW * j + k;
  endfunction
endpackage

// File: rtl/leak_key_recover_if.sv
// leak_key_recover_if: observation handshake in, status and recovered key out; master drives observations, slave is the solver
interface leak_key_recover_if;
  import leak_pkg::*;
  logic start;
  logic obs_valid;
  logic obs_ready;
  logic [PW-1:0] obs_probe;
  logic [NK-1:0] obs_bits;
  logic busy;
  logic [3:0] rank;
  logic [7:0] dep_count;
  logic inconsistent;
  logic key_valid;
  logic [PW*NK-1:0] key_out;
  modport master(output start, obs_valid, obs_probe, obs_bits,
                 input obs_ready, busy, rank, dep_count, inconsistent, key_valid, key_out);
  modport slave(input start, obs_valid, obs_probe, obs_bits,
                output obs_ready, busy, rank, dep_count, inconsistent, key_valid, key_out);
endinterface

// File: rtl/leak_key_recover_row_reduce.sv
// gf2_row_reduce: out = base XOR every rows[i] selected by mask (combinational)
module gf2_row_reduce
  import leak_pkg::*;
(
  input  row_t          base,
  input  row_t          rows [PW],
  input  logic [PW-1:0] mask,
  output row_t          out
);
  always_comb begin
    out = base;
    for (int i = 0; i < PW; i++) out = mask[i] ? row_t'(out ^ rows[i]) : out;
  end
endmodule

// File: rtl/leak_key_recover.sv
// leak_key_recover: GF(2) Gaussian elimination of parity leaks into round-key low bytes; ports clk, rst, bus (observations in; ready/busy/rank/dep_count/inconsistent/key out)
module leak_key_recover
  import leak_pkg::*;
(
  input logic clk,
  input logic rst,
  leak_key_recover_if.slave bus
);
  state_t st;
  row_t basis [PW];
  row_t cur, base, red;
  logic [PW-1:0] bv, mask, low;
  logic [KW-1:0] k;
  logic [3:0] rank;
  logic [7:0] dep;
  logic inc, hit;
  logic [PW*NK-1:0] key;
  assign hit = cur.p[k];
  assign low = (PW'(1) << k) - PW'(1);
  assign base = st == S_BACKSUB ? basis[k] : cur;
  assign mask = st == S_BACKSUB ? basis[k].p & low : (hit && bv[k]) ? PW'(1) << k : '0;
  gf2_row_reduce u_red (.base(base), .rows(basis), .mask(mask), .out(red));
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      bv <= '0;
      rank <= '0;
      dep <= '0;
      inc <= 1'b0;
      k <= '0;
      cur <= '0;
    end else begin
      case (st)
        S_IDLE, S_DONE: if (bus.start) begin
          st <= S_COLLECT;
          bv <= '0;
          rank <= '0;
          dep <= '0;
          inc <= 1'b0;
        end
        S_COLLECT: if (bus.obs_valid) begin
          cur <= {bus.obs_probe, bus.obs_bits};
          k <= KW'(PW - 1);
          st <= S_REDUCE;
        end
        S_REDUCE: if (hit && !bv[k]) begin
          basis[k] <= cur;
          bv[k] <= 1'b1;
          rank <= rank + 4'd1;
          k <= KW'(1);
          st <= rank == 4'(PW - 1) ? S_BACKSUB : S_COLLECT;
        end else if (k == '0) begin
          dep <= dep == 8'hff ? dep : dep + 8'd1;
          inc <= inc | (red.r != '0);
          st <= S_COLLECT;
        end else begin
          cur <= red;
          k <= k - KW'(1);
        end
        S_BACKSUB: begin
          basis[k] <= red;
          k <= k + KW'(1);
          st <= k == KW'(PW - 1) ? S_DONE : S_BACKSUB;
        end
        default: st <= S_IDLE;
      endcase
    end
  end
  always_comb begin
    key = '0;
    for (int j = 0; j < NK; j++)
      for (int i = 0; i < PW; i++) key[key_index(j, i)] = basis[i].r[j] & (st == S_DONE);
  end
  assign bus.obs_ready = st == S_COLLECT;
  assign bus.busy = st inside {S_COLLECT, S_REDUCE, S_BACKSUB};
  assign bus.key_valid = st == S_DONE;
  assign bus.rank = rank;
  assign bus.dep_count = dep;
  assign bus.inconsistent = inc;
  assign bus.key_out = key;
endmodule

// File: tb/tb_leak_key_recover.sv
// tb_leak_key_recover: directed table-driven check of leak_key_recover
module tb_leak_key_recover;
  import leak_pkg::*;
  typedef struct {
    logic [7:0] probe;
    logic [3:0] rank;
    int lat;
  } vec_t;
  localparam logic [63:0] KEY = 64'hA6D2AE2816157E2B;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int cnt;
  logic [7:0] keys [8] = '{8'h2B, 8'h7E, 8'h15, 8'h16, 8'h28, 8'hAE, 8'hD2, 8'hA6};
  vec_t tbl [16];
  leak_key_recover_if bus();
  leak_key_recover dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic [7:0] leak(input logic [7:0] p);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = ^(p & keys[j]);
    return b;
  endfunction
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic send(input logic [7:0] p, input logic [7:0] b);
    int c = 0;
    while (!bus.obs_ready && c < 100) begin
      tick();
      c++;
    end
    chk("obs_ready wait", bus.obs_ready, 1);
    bus.obs_probe = p;
    bus.obs_bits = b;
    bus.obs_valid = 1'b1;
    tick();
    bus.obs_valid = 1'b0;
  endtask
  task automatic wait_evt(output int c);
    c = 0;
    while (!(bus.obs_ready || bus.key_valid) && c < 100) begin
      tick();
      c++;
    end
  endtask
  task automatic run_table(input int lo, input int hi);
    int c;
    for (int i = lo; i <= hi; i++) begin
      send(tbl[i].probe, leak(tbl[i].probe));
      wait_evt(c);
      chk($sformatf("latency[%0d]", i), c, tbl[i].lat);
      chk($sformatf("rank[%0d]", i), bus.rank, tbl[i].rank);
    end
    chk("key_valid", bus.key_valid, 1);
    chk("key_out", bus.key_out, KEY);
    chk("dep_count", bus.dep_count, 0);
    chk("busy done", bus.busy, 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.obs_valid = 1'b0;
    bus.obs_probe = '0;
    bus.obs_bits = '0;
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{8'(1 << i), 4'(i + 1), i == 7 ? 8 : 8 - i};
      tbl[8 + i] = '{8'hFF >> i, 4'(i + 1), i == 7 ? 15 : i + 1};
    end
    tick();
    tick();
    chk("rst obs_ready", bus.obs_ready, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst rank", bus.rank, 0);
    chk("rst dep_count", bus.dep_count, 0);
    chk("rst inconsistent", bus.inconsistent, 0);
    chk("rst key_valid", bus.key_valid, 0);
    chk("rst key_out", bus.key_out, 0);
    rst = 1'b0;
    pulse_start();
    chk("start obs_ready", bus.obs_ready, 1);
    chk("start busy", bus.busy, 1);
    run_table(0, 7);
    bus.obs_probe = 8'h55;
    bus.obs_bits = 8'hFF;
    bus.obs_valid = 1'b1;
    tick();
    tick();
    bus.obs_valid = 1'b0;
    chk("done ignores obs rank", bus.rank, 8);
    chk("done ignores obs key", bus.key_out, KEY);
    pulse_start();
    chk("restart key_valid", bus.key_valid, 0);
    chk("restart rank", bus.rank, 0);
    chk("restart key_out", bus.key_out, 0);
    chk("restart obs_ready", bus.obs_ready, 1);
    run_table(8, 15);
    pulse_start();
    send(8'h00, 8'h00);
    wait_evt(cnt);
    chk("zero latency", cnt, 8);
    chk("zero dep_count", bus.dep_count, 1);
    chk("zero rank", bus.rank, 0);
    chk("zero inconsistent", bus.inconsistent, 0);
    pulse_start();
    chk("start ignored dep", bus.dep_count, 1);
    chk("start ignored ready", bus.obs_ready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_start();
    send(8'h01, 8'h05);
    wait_evt(cnt);
    send(8'h01, 8'h04);
    wait_evt(cnt);
    chk("dup latency", cnt, 8);
    chk("dup dep_count", bus.dep_count, 1);
    chk("dup inconsistent", bus.inconsistent, 1);
    chk("dup rank", bus.rank, 1);
    send(8'h02, 8'h00);
    wait_evt(cnt);
    chk("sticky inconsistent", bus.inconsistent, 1);
    chk("sticky rank", bus.rank, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send(8'(1 << i), leak(8'(1 << i)));
      wait_evt(cnt);
    end
    chk("pre-reset rank", bus.rank, 4);
    send(8'h10, leak(8'h10));
    tick();
    chk("mid reduce busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst obs_ready", bus.obs_ready, 0);
    chk("mid rst busy", bus.busy, 0);
    chk("mid rst rank", bus.rank, 0);
    chk("mid rst key_valid", bus.key_valid, 0);
    chk("mid rst key_out", bus.key_out, 0);
    pulse_start();
    run_table(0, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
